// File: rtl/ahb_flash_writer_spi.sv
// AHB-Lite flash programmer with a hardware SPI byte shifter (single/dual/quad lanes).
// Optional feature: define AHB_FLASH_WRITER_IRQ_EN to add the IE register (0x18) and the irq output.
module ahb_flash_writer_spi #(
    parameter int unsigned DIV_W    = 8,
    parameter int unsigned DIV_RST  = 1,
    parameter logic [31:0] ID_VALUE = 32'hABCD0002
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    input  logic        fr_sck,
    input  logic        fr_ce_n,
    input  logic        fr_douten,
    input  logic [3:0]  fr_dout,
    output logic [3:0]  fr_din,
    output logic        fm_sck,
    output logic        fm_ce_n,
    output logic [3:0]  fm_dout,
    output logic [3:0]  fm_douten,
    input  logic [3:0]  fm_din
`ifdef AHB_FLASH_WRITER_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;

    localparam logic [7:0] A_WE   = 8'h00;
    localparam logic [7:0] A_SS   = 8'h04;
    localparam logic [7:0] A_CFG  = 8'h08;
    localparam logic [7:0] A_DATA = 8'h0C;
    localparam logic [7:0] A_STAT = 8'h10;
    localparam logic [7:0] A_ID   = 8'h14;
    localparam logic [7:0] A_IE   = 8'h18;

    logic             r_wr, r_rd;
    logic [7:0]       r_addr;
    logic             r_we, r_ss, r_dir, r_done, r_sck;
    logic [1:0]       r_mode, r_state;
    logic [DIV_W-1:0] r_div, r_cnt;
    logic [7:0]       r_tx, r_rx, r_rxbyte;
    logic [3:0]       r_beats;

    logic             w_sel, w_busy, w_tc, w_we_nxt, w_start, w_fin;
    logic [2:0]       w_lanes;
    logic [3:0]       w_beats_init, w_lane_dout, w_lane_oe;
    logic [7:0]       w_rx_shift;
    logic             w_unused;

    assign w_unused  = ^{HSIZE, HADDR[31:8], HTRANS[0]};
    assign HREADYOUT = 1'b1;
    assign w_sel     = HSEL & HTRANS[1] & HREADY;
    assign w_busy    = (r_state != S_IDLE);
    assign w_tc      = (r_cnt == r_div);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wr   <= 1'b0;
            r_rd   <= 1'b0;
            r_addr <= '0;
        end else if (HREADY) begin
            r_wr <= w_sel & HWRITE;
            r_rd <= w_sel & ~HWRITE;
            if (w_sel) r_addr <= HADDR[7:0];
        end
    end

    // Clearing WE must abort the shifter on the same edge it takes effect.
    assign w_we_nxt = (r_wr && r_addr == A_WE && HWDATA[31:8] == 24'hA5A855) ? HWDATA[0] : r_we;
    assign w_start  = r_wr && r_addr == A_DATA && r_we && !w_busy;
    assign w_fin    = (r_state == S_HIGH) && w_tc && (r_beats == 4'd1) && w_we_nxt;

    always_comb begin
        w_lanes      = 3'd4;
        w_beats_init = 4'd2;
        w_lane_dout  = r_tx[7:4];
        w_rx_shift   = {r_rx[3:0], fm_din};
        w_lane_oe    = 4'b1111;
        case (r_mode)
            2'd0: begin
                w_lanes      = 3'd1;
                w_beats_init = 4'd8;
                w_lane_dout  = {3'b000, r_tx[7]};
                w_rx_shift   = {r_rx[6:0], fm_din[1]};
                w_lane_oe    = 4'b0001;
            end
            2'd1: begin
                w_lanes      = 3'd2;
                w_beats_init = 4'd4;
                w_lane_dout  = {2'b00, r_tx[7:6]};
                w_rx_shift   = {r_rx[5:0], fm_din[1:0]};
                w_lane_oe    = 4'b0011;
            end
            default: ;
        endcase
        if (r_dir) w_lane_oe = 4'b0000;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_we   <= 1'b0;
            r_ss   <= 1'b1;
            r_mode <= '0;
            r_dir  <= 1'b0;
            r_div  <= DIV_W'(DIV_RST);
            r_done <= 1'b0;
        end else begin
            r_we <= w_we_nxt;
            if (r_wr && r_addr == A_SS) r_ss <= HWDATA[0];
            if (r_wr && r_addr == A_CFG && !w_busy) begin
                r_mode <= HWDATA[1:0];
                r_dir  <= HWDATA[2];
                r_div  <= HWDATA[8 +: DIV_W];
            end
            if (w_fin) r_done <= 1'b1;
            else if (r_wr && r_addr == A_STAT && HWDATA[1]) r_done <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state  <= S_IDLE;
            r_sck    <= 1'b0;
            r_cnt    <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
            r_rxbyte <= '0;
            r_beats  <= '0;
        end else if (w_busy && !w_we_nxt) begin
            r_state <= S_IDLE;
            r_sck   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_tx    <= HWDATA[7:0];
                    r_beats <= w_beats_init;
                    r_sck   <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_LOW;
                end
                S_LOW: if (w_tc) begin
                    r_state <= S_HIGH;
                    r_sck   <= 1'b1;
                    r_cnt   <= '0;
                    r_rx    <= w_rx_shift;
                end else begin
                    r_cnt <= r_cnt + DIV_W'(1);
                end
                S_HIGH: if (w_tc) begin
                    r_sck   <= 1'b0;
                    r_cnt   <= '0;
                    r_beats <= r_beats - 4'd1;
                    if (r_beats == 4'd1) begin
                        r_rxbyte <= r_rx;
                        r_state  <= S_IDLE;
                    end else begin
                        r_tx    <= r_tx << w_lanes;
                        r_state <= S_LOW;
                    end
                end else begin
                    r_cnt <= r_cnt + DIV_W'(1);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef AHB_FLASH_WRITER_IRQ_EN
    logic r_ie, r_irq;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (r_wr && r_addr == A_IE) r_ie <= HWDATA[0];
            r_irq <= r_ie & r_done;
        end
    end
    assign irq = r_irq;
`endif

    always_comb begin
        HRDATA = '0;
        if (r_rd) begin
            case (r_addr)
                A_WE:   HRDATA[0] = r_we;
                A_SS:   HRDATA[0] = r_ss;
                A_CFG: begin
                    HRDATA[1:0]        = r_mode;
                    HRDATA[2]          = r_dir;
                    HRDATA[8 +: DIV_W] = r_div;
                end
                A_DATA: HRDATA[7:0] = r_rxbyte;
                A_STAT: HRDATA[1:0] = {r_done, w_busy};
                A_ID:   HRDATA = ID_VALUE;
`ifdef AHB_FLASH_WRITER_IRQ_EN
                A_IE:   HRDATA[0] = r_ie;
`endif
                default: ;
            endcase
        end
    end

    assign fr_din    = fm_din;
    assign fm_sck    = r_we ? r_sck       : fr_sck;
    assign fm_ce_n   = r_we ? r_ss        : fr_ce_n;
    assign fm_dout   = r_we ? w_lane_dout : fr_dout;
    assign fm_douten = r_we ? w_lane_oe   : {4{fr_douten}};

endmodule
